// File: rtl/rank_read_return_collector.sv
// rtl/rank_read_return_collector.sv - matches DDR4 read beats to issued tags and returns assembled lines.
// Optional RDRET_STATS_EN adds saturating linesReturned/beatsDropped counters.
module rank_read_return_collector #(
    parameter int MEM_DATAWIDTH = 64,
    parameter int BURST_LENGTH  = 8,
    parameter int TAGWIDTH      = 4,
    parameter int TAG_DEPTH     = 8,
    parameter int TIMEOUT       = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  rdIssueValid,
    input  logic [TAGWIDTH-1:0]                   rdIssueTag,
    output logic                                  rdIssueReady,
    input  logic                                  rankDQRdValid,
    input  logic [MEM_DATAWIDTH-1:0]              rankRdData,
    output logic                                  lineValid,
    output logic [MEM_DATAWIDTH*BURST_LENGTH-1:0] lineData,
    output logic [TAGWIDTH-1:0]                   lineTag,
    input  logic                                  lineReady,
    output logic [$clog2(TAG_DEPTH):0]            outstanding,
    output logic                                  errOrphan,
    output logic                                  errOverrun,
`ifdef RDRET_STATS_EN
    output logic [31:0]                           linesReturned,
    output logic [15:0]                           beatsDropped,
`endif
    output logic                                  errTimeout
);

    localparam int PW   = $clog2(TAG_DEPTH);
    localparam int CW   = PW + 1;
    localparam int BCW  = $clog2(BURST_LENGTH);
    localparam int AGEW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(TAG_DEPTH);
    localparam logic [BCW-1:0]  LAST_BEAT = BCW'(BURST_LENGTH - 1);
    localparam logic [AGEW-1:0] AGE_MAX   = AGEW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic                ready_q;
    logic [BCW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [AGEW-1:0]     age_q, age_d;
    logic [TAGWIDTH-1:0] tag_q, tag_d;
    logic                orphan_q, orphan_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic [TAGWIDTH-1:0] tag_mem [TAG_DEPTH];
    logic [MEM_DATAWIDTH*BURST_LENGTH-1:0] line_q;

    logic q_empty, push, pop, store, handshake, drop;

    assign q_empty = (count_q == '0);
    assign push    = rdIssueValid && ready_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        age_d      = age_q;
        tag_d      = tag_q;
        orphan_d   = orphan_q;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;
        pop        = 1'b0;
        store      = 1'b0;
        handshake  = 1'b0;
        drop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rankDQRdValid) begin
                    if (!q_empty) begin
                        store      = 1'b1;
                        beat_cnt_d = BCW'(1);
                        state_d    = S_COLLECT;
                    end else begin
                        orphan_d = 1'b1;
                        drop     = 1'b1;
                    end
                end else if (!q_empty) begin
                    // Head tag never saw its first beat: retire it so later tags can proceed.
                    if (age_q == AGE_MAX) begin
                        timeout_d = 1'b1;
                        pop       = 1'b1;
                    end else begin
                        age_d = age_q + AGEW'(1);
                    end
                end
            end
            S_COLLECT: begin
                if (rankDQRdValid) begin
                    store      = 1'b1;
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        pop     = 1'b1;
                        tag_d   = tag_mem[rd_ptr_q];
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (rankDQRdValid) begin
                    overrun_d = 1'b1;
                    drop      = 1'b1;
                end
                if (lineReady) begin
                    handshake = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop || q_empty) begin
            age_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            beat_cnt_q <= '0;
            age_q      <= '0;
            tag_q      <= '0;
            orphan_q   <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ready_q    <= (count_d != FULL_CNT);
            beat_cnt_q <= beat_cnt_d;
            age_q      <= age_d;
            tag_q      <= tag_d;
            orphan_q   <= orphan_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage arrays carry no reset; their contents are qualified by pointers/state.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= rdIssueTag;
        end
        for (int k = 0; k < BURST_LENGTH; k++) begin
            if (store && (beat_cnt_q == BCW'(k))) begin
                line_q[k*MEM_DATAWIDTH +: MEM_DATAWIDTH] <= rankRdData;
            end
        end
    end

`ifdef RDRET_STATS_EN
    logic [31:0] lines_q;
    logic [15:0] drops_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines_q <= '0;
            drops_q <= '0;
        end else begin
            if (handshake && (lines_q != '1)) begin
                lines_q <= lines_q + 32'd1;
            end
            if (drop && (drops_q != '1)) begin
                drops_q <= drops_q + 16'd1;
            end
        end
    end

    assign linesReturned = lines_q;
    assign beatsDropped  = drops_q;
`endif

    assign rdIssueReady = ready_q;
    assign lineValid    = (state_q == S_HOLD);
    assign lineData     = line_q;
    assign lineTag      = tag_q;
    assign outstanding  = count_q;
    assign errOrphan    = orphan_q;
    assign errOverrun   = overrun_q;
    assign errTimeout   = timeout_q;

endmodule

// File: tb/tb_rank_read_return_collector.sv
// tb/tb_rank_read_return_collector.sv - scoreboard bench for rank_read_return_collector.
module tb_rank_read_return_collector;

    logic         clk;
    logic         rst_n;
    logic         rdIssueValid;
    logic [3:0]   rdIssueTag;
    logic         rdIssueReady;
    logic         rankDQRdValid;
    logic [63:0]  rankRdData;
    logic         lineValid;
    logic [511:0] lineData;
    logic [3:0]   lineTag;
    logic         lineReady;
    logic [3:0]   outstanding;
    logic         errOrphan;
    logic         errOverrun;
    logic         errTimeout;
`ifdef RDRET_STATS_EN
    logic [31:0]  linesReturned;
    logic [15:0]  beatsDropped;
`endif

    rank_read_return_collector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdIssueValid  (rdIssueValid),
        .rdIssueTag    (rdIssueTag),
        .rdIssueReady  (rdIssueReady),
        .rankDQRdValid (rankDQRdValid),
        .rankRdData    (rankRdData),
        .lineValid     (lineValid),
        .lineData      (lineData),
        .lineTag       (lineTag),
        .lineReady     (lineReady),
        .outstanding   (outstanding),
        .errOrphan     (errOrphan),
        .errOverrun    (errOverrun),
`ifdef RDRET_STATS_EN
        .linesReturned (linesReturned),
        .beatsDropped  (beatsDropped),
`endif
        .errTimeout    (errTimeout)
    );

    typedef struct {
        logic [3:0]   tag;
        logic [511:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   lines_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [511:0] make_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic push_tag(input logic [3:0] t, input bit expect_line, input logic [63:0] base);
        rdIssueValid = 1'b1;
        rdIssueTag   = t;
        tick();
        rdIssueValid = 1'b0;
        if (expect_line) sb.push_back('{t, make_line(base)});
    endtask

    task automatic send_burst(input logic [63:0] base, input int gap_at, input int gap_len);
        for (int k = 0; k < 8; k++) begin
            if (k == gap_at) begin
                rankDQRdValid = 1'b0;
                repeat (gap_len) tick();
            end
            rankDQRdValid = 1'b1;
            rankRdData    = base + 64'(k);
            tick();
        end
        rankDQRdValid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(name, 512'(sb.size()), 512'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && lineValid && lineReady) begin
            chk("sb_nonempty", 512'(sb.size() != 0), 512'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("line_tag", 512'(lineTag), 512'(mon_e.tag));
                chk("line_data", lineData, mon_e.data);
                lines_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        rdIssueValid = 1'b0;
        rdIssueTag = '0;
        rankDQRdValid = 1'b0;
        rankRdData = '0;
        lineReady = 1'b1;
        repeat (3) tick();
        settle();
        chk("rst_lineValid", 512'(lineValid), 512'd0);
        chk("rst_lineTag", 512'(lineTag), 512'd0);
        chk("rst_outstanding", 512'(outstanding), 512'd0);
        chk("rst_rdIssueReady", 512'(rdIssueReady), 512'd1);
        chk("rst_errs", 512'({errOrphan, errOverrun, errTimeout}), 512'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single contiguous burst, tag 0x3
        push_tag(4'h3, 1'b1, 64'd0);
        for (int k = 0; k < 7; k++) begin
            rankDQRdValid = 1'b1;
            rankRdData    = 64'(k);
            tick();
        end
        settle();
        chk("t1_outstanding_pre", 512'(outstanding), 512'd1);
        chk("t1_lineValid_pre", 512'(lineValid), 512'd0);
        rankRdData = 64'd7;
        tick();
        rankDQRdValid = 1'b0;
        settle();
        chk("t1_lineValid", 512'(lineValid), 512'd1);
        chk("t1_lineTag", 512'(lineTag), 512'h3);
        chk("t1_outstanding_post", 512'(outstanding), 512'd0);
        tick();
        settle();
        chk("t1_lineValid_fall", 512'(lineValid), 512'd0);

        // two bursts with mid-burst gaps, returned in order
        push_tag(4'h1, 1'b1, 64'h100);
        push_tag(4'h2, 1'b1, 64'h200);
        send_burst(64'h100, 3, 3);
        repeat (2) tick();
        send_burst(64'h200, 5, 3);
        wait_drain("t2_drain");
        settle();
        chk("t2_no_errs", 512'({errOrphan, errOverrun, errTimeout}), 512'd0);

        // fill the tag queue, then an ignored push
        for (int i = 0; i < 8; i++) push_tag(4'(i), 1'b1, 64'h300 + 64'(i * 16));
        settle();
        chk("t3_ready_full", 512'(rdIssueReady), 512'd0);
        chk("t3_outstanding_full", 512'(outstanding), 512'd8);
        push_tag(4'h9, 1'b0, 64'd0);
        settle();
        chk("t3_outstanding_after_ignored", 512'(outstanding), 512'd8);
        for (int i = 0; i < 8; i++) begin
            send_burst(64'h300 + 64'(i * 16), 8, 0);
            repeat (2) tick();
        end
        wait_drain("t3_drain");
        settle();
        chk("t3_outstanding_empty", 512'(outstanding), 512'd0);
        chk("t3_ready_empty", 512'(rdIssueReady), 512'd1);

        // orphan beat
        rankDQRdValid = 1'b1;
        rankRdData    = 64'hBAD;
        tick();
        rankDQRdValid = 1'b0;
        settle();
        chk("t4_errOrphan", 512'(errOrphan), 512'd1);
        chk("t4_lineValid", 512'(lineValid), 512'd0);
        repeat (3) tick();
        settle();
        chk("t4_lineValid_later", 512'(lineValid), 512'd0);
        chk("t4_outstanding", 512'(outstanding), 512'd0);

        // timeout of tag 0x5, then tag 0x6 served normally
        push_tag(4'h5, 1'b0, 64'd0);
        n = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            settle();
            if (errTimeout) begin
                n = c;
                break;
            end
        end
        chk("t5_timeout_cycle", 512'(n), 512'd64);
        chk("t5_outstanding", 512'(outstanding), 512'd0);
        chk("t5_lineValid", 512'(lineValid), 512'd0);
        tick();
        push_tag(4'h6, 1'b1, 64'h600);
        send_burst(64'h600, 2, 1);
        wait_drain("t5_drain");

        // held line, overrun beats, reset mid-stream
        lineReady = 1'b0;
        repeat (2) tick();
        push_tag(4'h7, 1'b1, 64'h700);
        send_burst(64'h700, 8, 0);
        settle();
        chk("t6_lineValid_hold", 512'(lineValid), 512'd1);
        chk("t6_lineTag_hold", 512'(lineTag), 512'h7);
        chk("t6_lineData_hold", lineData, make_line(64'h700));
        rankDQRdValid = 1'b1;
        rankRdData    = 64'hDEAD_0001;
        tick();
        rankRdData    = 64'hDEAD_0002;
        tick();
        settle();
        chk("t6_errOverrun", 512'(errOverrun), 512'd1);
        chk("t6_lineValid_still", 512'(lineValid), 512'd1);
        chk("t6_lineData_stable", lineData, make_line(64'h700));
        void'(sb.pop_front());
        rst_n = 1'b0;
        settle();
        chk("t6_rst_lineValid", 512'(lineValid), 512'd0);
        chk("t6_rst_lineTag", 512'(lineTag), 512'd0);
        chk("t6_rst_outstanding", 512'(outstanding), 512'd0);
        chk("t6_rst_rdIssueReady", 512'(rdIssueReady), 512'd1);
        chk("t6_rst_errs", 512'({errOrphan, errOverrun, errTimeout}), 512'd0);
        rankDQRdValid = 1'b0;
        tick();
        rst_n = 1'b1;
        lineReady = 1'b1;
        tick();

        push_tag(4'hC, 1'b1, 64'hC00);
        send_burst(64'hC00, 8, 0);
        wait_drain("t7_drain");
        settle();
        chk("lines_seen", 512'(lines_seen), 512'd13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
